bin_to_bcd: RTL and testbench

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/bin_to_bcd.sv | 110 +++++++++++
 tb/tb_bin_to_bcd.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock,
// BIN_W shift cycles per conversion, saturating to all nines on overflow.
//
// state | meaning
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | add-3 adjust then shift, one input bit per clock
module bin_to_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int SCR_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_VAL = 64'(10**DIGITS) - 64'd1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [BIN_W-1:0]       shift_q, shift_d;
  logic [SCR_W-1:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_pend_q, ovf_pend_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [SCR_W-1:0]       scratch_adj;
  logic [SCR_W+BIN_W-1:0] shifted;

  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < SCR_W/4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {scratch_adj, shift_q} << 1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = 64'(bin) > MAX_VAL;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[SCR_W+BIN_W-1:BIN_W];
        shift_d   = shifted[BIN_W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        // Last shift: the freshly shifted scratch is the final BCD value.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovf_pend_q ? {DIGITS{4'd9}} : shifted[BIN_W +: 4*DIGITS];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: accepted starts push expected results,
// a negedge monitor pops and compares on done.
module tb_bin_to_bcd;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BIN_W-1:0]  bin = '0;
  logic              start = 1'b0;
  logic              busy, done, ovf;
  logic [15:0]       bcd;

  bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .bin(bin), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   mcnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [15:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [16:0] ref_conv(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v/1000), 4'((v/100)%10), 4'((v/10)%10), 4'(v%10)};
  endfunction

  // Timing model: a start is accepted when no conversion is outstanding.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      exp_t e;
      logic [16:0] r;
      cyc++;
      if (mcnt > 0) mcnt--;
      else if (start) begin
        r     = ref_conv(int'(bin));
        e.bcd = r[15:0];
        e.ovf = r[16];
        e.due = cyc + BIN_W;
        exp_q.push_back(e);
        mcnt  = BIN_W;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_bcd = '0;
      hold_ovf = 1'b0;
    end
    check("busy", 32'(busy), 32'(mcnt > 0));
    if (busy && done) check("busy_and_done", 32'(busy & done), 32'd0);
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else begin
        check("done_latency", 32'(cyc), 32'(exp_q[0].due));
        check("bcd", 32'(bcd), 32'(exp_q[0].bcd));
        check("ovf", 32'(ovf), 32'(exp_q[0].ovf));
        hold_bcd = exp_q[0].bcd;
        hold_ovf = exp_q[0].ovf;
        void'(exp_q.pop_front());
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("missing_done", 32'(done), 32'd1);
        void'(exp_q.pop_front());
      end
      check("bcd_hold", 32'(bcd), 32'(hold_bcd));
      check("ovf_hold", 32'(ovf), 32'(hold_ovf));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((mcnt != 0 || exp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(n), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic issue(input int v);
    @(posedge clk); #1;
    bin   = BIN_W'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic convert(input int v);
    issue(v);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vec[] = '{0, 1234, 9999, 12000, 7, 16383, 10000, 9, 10, 99, 100, 999, 1000, 5050};
    // Start held during reset must be ignored.
    bin   = BIN_W'(1234);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vec[i]) convert(vec[i]);

    // Continuous start with bin changing every cycle.
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      start = 1'b1;
      bin   = BIN_W'((k*1237 + 5) % 16384);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-conversion aborts without a done pulse.
    issue(5678);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    wait_idle();
    check("abort_bcd_after", 32'(bcd), 32'd0);
    convert(42);
    check("after_abort_bcd", 32'(bcd), 32'h0042);

    for (int k = 0; k < 30; k++) convert(int'($urandom_range(0, 16383)));

    wait_idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
